// File: rtl/mkio_channel_arbiter.sv
// Redundant MKIO channel arbiter: locks onto the first active healthy channel,
// routes it to the receiver core and gates the transmitter with a post-TX guard.
module mkio_channel_arbiter #(
  parameter int NCH       = 2,
  parameter int ACT_MIN   = 4,
  parameter int IDLE_TO   = 128,
  parameter int GUARD     = 10,
  parameter int FAULT_MAX = 3,
  localparam int AW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk32,
  input  logic           reset,
  input  logic [NCH-1:0] di1,
  input  logic [NCH-1:0] di0,
  output logic [NCH-1:0] do1,
  output logic [NCH-1:0] do0,
  output logic [NCH-1:0] rx_strob,
  output logic [NCH-1:0] tx_inhibit,
  input  logic [NCH-1:0] ch_enable,
  output logic           core_di1,
  output logic           core_di0,
  input  logic           core_do1,
  input  logic           core_do0,
  input  logic           tx_busy,
  input  logic           rx_done,
  input  logic           rx_error,
  output logic           locked,
  output logic [AW-1:0]  active_ch,
  output logic [NCH-1:0] ch_fault
);

  localparam int ACW = $clog2(ACT_MIN + 1);
  localparam int QW  = $clog2(IDLE_TO + 1);
  localparam int GW  = $clog2(GUARD + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_TX, ST_GUARD} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    active_ch_q, active_ch_d;
  logic [NCH-1:0]   di1_m_q, di0_m_q, di1_s_q, di0_s_q;
  logic [ACW-1:0]   act_cnt_q [NCH];
  logic [ACW-1:0]   act_cnt_d [NCH];
  logic [3:0]       fault_cnt_q [NCH];
  logic [3:0]       fault_cnt_d [NCH];
  logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
  logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
  logic [NCH-1:0]   ch_fault_q, ch_fault_d;
  logic [NCH-1:0]   do1_q, do0_q, do1_d, do0_d;
  logic             tx_busy_q;
  logic             tx_rise, tx_fall, lock_found;
  logic [NCH-1:0]   chan_active, chan_quiet;

  assign chan_active = di1_s_q ^ di0_s_q;
  assign chan_quiet  = ~(di1_s_q | di0_s_q);
  assign tx_rise     = tx_busy & ~tx_busy_q;
  assign tx_fall     = ~tx_busy & tx_busy_q;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      di1_m_q <= '0;
      di0_m_q <= '0;
      di1_s_q <= '0;
      di0_s_q <= '0;
    end else begin
      di1_m_q <= di1;
      di0_m_q <= di0;
      di1_s_q <= di1_m_q;
      di0_s_q <= di0_m_q;
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      active_ch_q <= '0;
      quiet_cnt_q <= '0;
      guard_cnt_q <= '0;
      ch_fault_q  <= '0;
      do1_q       <= '0;
      do0_q       <= '0;
      tx_busy_q   <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        act_cnt_q[c]   <= '0;
        fault_cnt_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      active_ch_q <= active_ch_d;
      quiet_cnt_q <= quiet_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      ch_fault_q  <= ch_fault_d;
      do1_q       <= do1_d;
      do0_q       <= do0_d;
      tx_busy_q   <= tx_busy;
      for (int unsigned c = 0; c < NCH; c++) begin
        act_cnt_q[c]   <= act_cnt_d[c];
        fault_cnt_q[c] <= fault_cnt_d[c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    active_ch_d = active_ch_q;
    quiet_cnt_d = '0;
    guard_cnt_d = '0;
    ch_fault_d  = ch_fault_q;
    fault_cnt_d = fault_cnt_q;
    do1_d       = '0;
    do0_d       = '0;
    lock_found  = 1'b0;

    for (int unsigned c = 0; c < NCH; c++) begin
      if (!chan_active[c])
        act_cnt_d[c] = '0;
      else if (act_cnt_q[c] == ACW'(ACT_MIN))
        act_cnt_d[c] = act_cnt_q[c];
      else
        act_cnt_d[c] = act_cnt_q[c] + ACW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        // ascending scan with a found flag keeps the lowest index
        for (int unsigned c = 0; c < NCH; c++) begin
          if (!lock_found && ch_enable[c] && !ch_fault_q[c] && chan_active[c] &&
              act_cnt_q[c] >= ACW'(ACT_MIN - 1)) begin
            lock_found  = 1'b1;
            state_d     = ST_LOCKED;
            active_ch_d = AW'(c);
          end
        end
      end
      ST_LOCKED: begin
        if (rx_error) begin
          if (fault_cnt_q[active_ch_q] != 4'hF)
            fault_cnt_d[active_ch_q] = fault_cnt_q[active_ch_q] + 4'd1;
          if (fault_cnt_d[active_ch_q] >= 4'(FAULT_MAX)) begin
            ch_fault_d[active_ch_q] = 1'b1;
            state_d                 = ST_IDLE;
          end
        end else if (rx_done) begin
          fault_cnt_d[active_ch_q] = '0;
        end
        if (state_d == ST_LOCKED) begin
          if (tx_rise)
            state_d = ST_TX;
          else if (chan_quiet[active_ch_q]) begin
            if (quiet_cnt_q == QW'(IDLE_TO - 1))
              state_d = ST_IDLE;
            else
              quiet_cnt_d = quiet_cnt_q + QW'(1);
          end
        end
      end
      ST_TX: begin
        if (tx_fall)
          state_d = ST_GUARD;
        else begin
          do1_d[active_ch_q] = core_do1;
          do0_d[active_ch_q] = core_do0;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GW'(GUARD - 1))
          state_d = ST_LOCKED;
        else
          guard_cnt_d = guard_cnt_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !ch_enable[active_ch_q]) begin
      state_d = ST_IDLE;
      do1_d   = '0;
      do0_d   = '0;
    end
    if (state_d == ST_IDLE)
      active_ch_d = '0;
  end

  always_comb begin
    rx_strob   = '1;
    tx_inhibit = '1;
    core_di1   = 1'b0;
    core_di0   = 1'b0;
    unique case (state_q)
      ST_LOCKED: begin
        core_di1 = di1_s_q[active_ch_q];
        core_di0 = di0_s_q[active_ch_q];
      end
      ST_TX: begin
        rx_strob[active_ch_q]   = 1'b0;
        tx_inhibit[active_ch_q] = 1'b0;
      end
      ST_GUARD: rx_strob[active_ch_q] = 1'b0;
      default: ;
    endcase
  end

  assign locked    = (state_q != ST_IDLE);
  assign active_ch = active_ch_q;
  assign ch_fault  = ch_fault_q;
  assign do1       = do1_q;
  assign do0       = do0_q;

endmodule

// File: doc/mkio_channel_arbiter.md
MKIO_CHANNEL_ARBITER -- requirements
Module: mkio_channel_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of redundant MKIO channels (2..4).
REQ-002 SHALL have parameter ACT_MIN, default 4: consecutive active clk32 cycles needed to lock a channel.
REQ-003 SHALL have parameter IDLE_TO, default 128: quiet clk32 cycles on the locked channel before release.
REQ-004 SHALL have parameter GUARD, default 10: clk32 cycles of receiver blanking after the end of transmission.
REQ-005 SHALL have parameter FAULT_MAX, default 3: consecutive receive errors that mark a channel faulty (4-bit, saturating).
REQ-006 SHALL have port clk32  in  1  system clock; all state is updated on its rising edge.
REQ-007 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports di1, di0  in  NCH  Manchester line inputs, one bit per channel, asynchronous to clk32.
REQ-009 SHALL have ports do1, do0  out  NCH  Manchester line outputs, one bit per channel.
REQ-010 SHALL have ports rx_strob, tx_inhibit  out  NCH  per-channel receiver enable (1 = enabled) and transmitter inhibit (1 = inhibited).
REQ-011 SHALL have port ch_enable  in  NCH  static channel enable mask from the host.
REQ-012 SHALL have ports core_di1, core_di0  out  1  selected line pair to the receiver core.
REQ-013 SHALL have ports core_do1, core_do0  in  1  line pair from the transmitter core.
REQ-014 SHALL have ports tx_busy, rx_done, rx_error  in  1  transmitter busy level, receiver word-done pulse, and receiver parity/format error pulse.
REQ-015 SHALL have ports locked (out, 1), active_ch (out, clog2(NCH)) and ch_fault (out, NCH): lock status, index of the selected channel, and per-channel fault flags.

Function
REQ-016 SHALL pass di1/di0 through a 2-flop synchronizer; all decisions use the synchronized values.
REQ-017 SHALL treat a channel as active in a cycle when di1 XOR di0 = 1, and as quiet when di1 = di0 = 0.
REQ-018 SHALL implement FSM states IDLE, LOCKED, TX, GUARD.
REQ-019 IDLE: SHALL lock the lowest-index channel that is enabled, not faulty and active for ACT_MIN consecutive cycles; in that cycle go to LOCKED, set active_ch and assert locked.
REQ-020 IDLE: core_di1/core_di0 SHALL be 0; tx_busy SHALL be ignored and do1/do0 SHALL stay 0.
REQ-021 LOCKED: core_di1/core_di0 SHALL equal the synchronized lines of active_ch; all other channels SHALL be masked.
REQ-022 LOCKED: a quiet counter SHALL count consecutive quiet cycles on active_ch and reset on any activity; at IDLE_TO the FSM SHALL go to IDLE and deassert locked.
REQ-023 LOCKED: a rising edge of tx_busy SHALL move the FSM to TX on the next cycle.
REQ-024 TX: do1/do0[active_ch] SHALL follow core_do1/core_do0 with one register stage; other channels' do SHALL be 0.
REQ-025 TX: tx_inhibit[active_ch] SHALL be 0 and rx_strob[active_ch] SHALL be 0; core_di SHALL be forced to 0.
REQ-026 TX: a falling edge of tx_busy SHALL move the FSM to GUARD; do outputs SHALL be 0 from that cycle.
REQ-027 GUARD: tx_inhibit[active_ch] SHALL be 1 and rx_strob[active_ch] SHALL stay 0 for exactly GUARD cycles; then the FSM SHALL return to LOCKED with the quiet counter cleared.
REQ-028 Channels not selected SHALL have rx_strob = 1 and tx_inhibit = 1 in every state.
REQ-029 rx_error in LOCKED SHALL increment the fault counter of active_ch (saturating); rx_done without rx_error in the same cycle SHALL clear it.
REQ-030 When the fault counter of a channel reaches FAULT_MAX, ch_fault SHALL be set (sticky until reset); if that channel is locked, the FSM SHALL go to IDLE.
REQ-031 If ch_enable[active_ch] drops in any non-IDLE state, the FSM SHALL go to IDLE on the next cycle, abort any TX, and drive do to 0.
REQ-032 If rx_done and rx_error arrive in the same cycle, the error SHALL take precedence.

Reset
REQ-033 On reset: FSM = IDLE; locked = 0; active_ch = 0; do1/do0 = 0; core_di1/core_di0 = 0; rx_strob = all 1; tx_inhibit = all 1; ch_fault = 0; all counters = 0.
REQ-034 Reset asserted mid-TX SHALL force all outputs to their reset values immediately, without waiting for a clock edge.

Verification (NCH=2, ACT_MIN=4, IDLE_TO=128, GUARD=10, FAULT_MAX=3)
REQ-035 Activity on ch1 only for 6 cycles -> locked=1 and active_ch=1 after 4 synchronized active cycles; core_di mirrors ch1.
REQ-036 Both channels active simultaneously -> ch0 is locked; ch1 activity is never seen on core_di.
REQ-037 Locked on ch0, tx_busy high for 40 cycles -> do on ch0 only, tx_inhibit[0]=0; then rx_strob[0]=0 for exactly 10 more cycles; ch1 do=0 throughout.
REQ-038 Locked, then 128 quiet cycles -> locked=0; 127 quiet cycles followed by 1 active cycle -> still locked.
REQ-039 Three rx_error pulses on ch0 -> ch_fault[0]=1 and IDLE; a later ch0 burst does not lock, a ch1 burst does.
REQ-040 Reset pulse during TX, and ch_enable[0] dropped during TX -> do=0 (immediately for reset, next cycle for disable) with reset values on the other outputs.
